// File: rtl/a2d_arbiter.sv
// Two-requester arbiter and sequencer for the shared SPI A2D (IR primary, aux bounded by IR burst limit).
// Define A2D_TIMEOUT_EN to add a per-transaction spi_done timeout with a sticky a2d_err flag.
module a2d_arbiter #(
  parameter int MAX_IR_BURST = 4,
  parameter int GAP_CYC      = 8,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_req,
  input  logic [2:0]  ir_chnl,
  output logic        ir_gnt,
  output logic        ir_done,
  output logic [11:0] ir_data,
  input  logic        aux_req,
  input  logic [2:0]  aux_chnl,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [11:0] aux_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        busy,
  output logic        a2d_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TX1  = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] TX2  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int BW = $clog2(MAX_IR_BURST + 1);

  logic [2:0]    state;
  logic          own_aux;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] burst_cnt;
  logic          burst_full, pick_ir, pick_aux;
  logic          in_tx, timeout, fin;
  logic [11:0]   fin_data;

  assign busy  = (state != IDLE);
  assign in_tx = (state == TX1) || (state == TX2);

  always_comb begin
    burst_full = (burst_cnt == BW'(MAX_IR_BURST));
    pick_ir    = ir_req && !(aux_req && burst_full);
    pick_aux   = aux_req && !pick_ir;
    // a missing spi_done only ends the transaction when the timeout option is built in
    fin        = ((state == TX2) && spi_done) || (in_tx && !spi_done && timeout);
    fin_data   = ((state == TX2) && spi_done) ? spi_rd[11:0] : 12'hFFF;
  end

`ifdef A2D_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;

  assign timeout = in_tx && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign a2d_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!in_tx || spi_done || timeout) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
      if (timeout && !spi_done) err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYC[0];
  assign timeout    = 1'b0;
  assign a2d_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own_aux   <= 1'b0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
      ir_gnt    <= 1'b0;
      aux_gnt   <= 1'b0;
      ir_done   <= 1'b0;
      aux_done  <= 1'b0;
      spi_wrt   <= 1'b0;
      spi_cmd   <= 16'h0000;
      ir_data   <= 12'h000;
      aux_data  <= 12'h000;
    end else begin
      ir_gnt   <= 1'b0;
      aux_gnt  <= 1'b0;
      ir_done  <= 1'b0;
      aux_done <= 1'b0;
      spi_wrt  <= 1'b0;
      case (state)
        IDLE: begin
          if (ir_req || aux_req) begin
            own_aux <= pick_aux;
            ir_gnt  <= pick_ir;
            aux_gnt <= pick_aux;
            spi_wrt <= 1'b1;
            spi_cmd <= {2'b00, (pick_aux ? aux_chnl : ir_chnl), 11'h000};
            // pick_ir with aux pending implies burst not full, so no explicit saturation needed
            burst_cnt <= (pick_ir && aux_req) ? burst_cnt + 1'b1 : '0;
            state   <= TX1;
          end
        end
        TX1: begin
          if (spi_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            spi_wrt <= 1'b1;
            state   <= TX2;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        TX2:     ;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin) begin
        state <= DONE;
        if (own_aux) begin
          aux_done <= 1'b1;
          aux_data <= fin_data;
        end else begin
          ir_done  <= 1'b1;
          ir_data  <= fin_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: reset, single-owner conversions, burst fairness, mid-run reset, dropped req.
module tb_a2d_arbiter;
  localparam int GAP = 8;

  logic        clk, rst;
  logic        ir_req, aux_req, spi_done;
  logic [2:0]  ir_chnl, aux_chnl;
  logic [15:0] spi_rd;
  logic        ir_gnt, ir_done, aux_gnt, aux_done, spi_wrt, busy, a2d_err;
  logic [11:0] ir_data, aux_data;
  logic [15:0] spi_cmd;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_ir_d, exp_aux_d;

  a2d_arbiter #(.MAX_IR_BURST(4), .GAP_CYC(GAP), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .ir_req(ir_req), .ir_chnl(ir_chnl), .ir_gnt(ir_gnt), .ir_done(ir_done), .ir_data(ir_data),
    .aux_req(aux_req), .aux_chnl(aux_chnl), .aux_gnt(aux_gnt), .aux_done(aux_done), .aux_data(aux_data),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd),
    .busy(busy), .a2d_err(a2d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wrt();
    int k = 0;
    while (spi_wrt !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wrt_seen", {31'd0, spi_wrt}, 32'd1);
  endtask

  // One full conversion: TX1 answered 2 clks after grant, TX2 answered 1 clk after its spi_wrt.
  task automatic conv(input logic [15:0] rd, input logic exp_ir, input logic [15:0] exp_cmd, input logic drop);
    int k;
    wait_wrt();
    chk("gnt_ir",  {31'd0, ir_gnt},  {31'd0, exp_ir});
    chk("gnt_aux", {31'd0, aux_gnt}, {31'd0, !exp_ir});
    chk("cmd1",    {16'd0, spi_cmd}, {16'd0, exp_cmd});
    if (drop) ir_req = 1'b0;
    @(negedge clk);
    chk("pulse1", {29'd0, spi_wrt, ir_gnt, aux_gnt}, 32'd0);
    chk("busy_tx1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    spi_done = 1'b1;
    spi_rd   = 16'hF5A5;
    k = 0;
    do begin
      @(negedge clk);
      spi_done = 1'b0;
      k++;
    end while (spi_wrt !== 1'b1 && k < 50);
    chk("gap_len", k, GAP + 1);
    chk("cmd2", {16'd0, spi_cmd}, {16'd0, exp_cmd});
    @(negedge clk);
    spi_done = 1'b1;
    spi_rd   = rd;
    @(negedge clk);
    spi_done = 1'b0;
    if (exp_ir) exp_ir_d = rd[11:0];
    else        exp_aux_d = rd[11:0];
    chk("done_ir",  {31'd0, ir_done},  {31'd0, exp_ir});
    chk("done_aux", {31'd0, aux_done}, {31'd0, !exp_ir});
    chk("ir_data",  {20'd0, ir_data},  {20'd0, exp_ir_d});
    chk("aux_data", {20'd0, aux_data}, {20'd0, exp_aux_d});
    @(negedge clk);
    chk("done_clr", {30'd0, ir_done, aux_done}, 32'd0);
    chk("idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ir_req = 1'b0; aux_req = 1'b0; ir_chnl = 3'd0; aux_chnl = 3'd0;
    spi_done = 1'b0; spi_rd = 16'h0000;
    exp_ir_d = 12'h000; exp_aux_d = 12'h000;
    repeat (2) @(negedge clk);
    chk("rst_ctl",  {26'd0, ir_gnt, ir_done, aux_gnt, aux_done, spi_wrt, busy}, 32'd0);
    chk("rst_cmd",  {16'd0, spi_cmd}, 32'd0);
    chk("rst_data", {8'd0, ir_data, aux_data}, 32'd0);
    chk("rst_err",  {31'd0, a2d_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // stray spi_done while idle is ignored
    spi_done = 1'b1; spi_rd = 16'h0123;
    @(negedge clk);
    spi_done = 1'b0;
    chk("stray_done", {28'd0, busy, ir_done, aux_done, spi_wrt}, 32'd0);
    chk("stray_data", {8'd0, ir_data, aux_data}, 32'd0);

    // IR only
    ir_req = 1'b1; ir_chnl = 3'd3;
    conv(16'h0ABC, 1'b1, 16'h1800, 1'b0);
    ir_req = 1'b0;

    // aux only
    aux_req = 1'b1; aux_chnl = 3'd7;
    conv(16'h5DEF, 1'b0, 16'h3800, 1'b0);
    aux_req = 1'b0;

    // both held: IR x4, then aux forced in, then IR again
    ir_req = 1'b1; ir_chnl = 3'd1; aux_req = 1'b1; aux_chnl = 3'd5;
    for (int i = 0; i < 6; i++) begin
      logic [11:0] lo;
      lo = 12'h321 + 12'(i);
      if (i == 4) conv({4'hF, lo}, 1'b0, 16'h2800, 1'b0);
      else        conv({4'hF, lo}, 1'b1, 16'h0800, 1'b0);
    end
    ir_req = 1'b0; aux_req = 1'b0;
    @(negedge clk);
    chk("both_drop_idle", {31'd0, busy}, 32'd0);

    // reset during GAP aborts the conversion
    ir_req = 1'b1; ir_chnl = 3'd2;
    wait_wrt();
    @(negedge clk);
    @(negedge clk);
    spi_done = 1'b1; spi_rd = 16'h0000;
    @(negedge clk);
    spi_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ir_d = 12'h000; exp_aux_d = 12'h000;
    chk("mid_rst_ctl",  {26'd0, ir_gnt, ir_done, aux_gnt, aux_done, spi_wrt, busy}, 32'd0);
    chk("mid_rst_cmd",  {16'd0, spi_cmd}, 32'd0);
    chk("mid_rst_data", {8'd0, ir_data, aux_data}, 32'd0);
    conv(16'h0777, 1'b1, 16'h1000, 1'b0);
    ir_req = 1'b0;

    // IR drops its request right after the grant
    ir_req = 1'b1; ir_chnl = 3'd6;
    conv(16'h0246, 1'b1, 16'h3000, 1'b1);
    repeat (3) @(negedge clk);
    chk("drop_no_regrant", {30'd0, busy, ir_done}, 32'd0);
    chk("err_clear", {31'd0, a2d_err}, 32'd0);

`ifdef A2D_TIMEOUT_EN
    ir_req = 1'b1; ir_chnl = 3'd0;
    wait_wrt();
    repeat (63) @(negedge clk);
    chk("to_pre_done", {30'd0, ir_done, a2d_err}, 32'd0);
    @(negedge clk);
    ir_req = 1'b0;
    chk("to_done", {31'd0, ir_done}, 32'd1);
    chk("to_err",  {31'd0, a2d_err}, 32'd1);
    chk("to_data", {20'd0, ir_data}, 32'hFFF);
    @(negedge clk);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_sticky", {31'd0, a2d_err}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
